// File: rtl/sync_cmd_fifo.sv
// Parametrised single-clock command FIFO with programmable thresholds,
// standard or first-word-fall-through read mode and overflow/underflow pulses.
module sync_cmd_fifo #(
  parameter int DATA_W            = 128,
  parameter int ADDR_W            = 4,
  parameter int PROG_FULL_THRESH  = 14,
  parameter int PROG_EMPTY_THRESH = 2,
  parameter int FWFT              = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   data_count,
  output logic              prog_full,
  output logic              prog_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PF_CNT    = (ADDR_W+1)'(PROG_FULL_THRESH);
  localparam logic [ADDR_W:0] PE_CNT    = (ADDR_W+1)'(PROG_EMPTY_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_nxt;
  logic              wr_acc;
  logic              rd_acc;
  logic              full_r;
  logic              empty_r;
  logic              prog_full_r;
  logic              prog_empty_r;
  logic              overflow_r;
  logic              underflow_r;

  // Acceptance uses only registered flags, so no request reaches a flag combinationally.
  always_comb begin
    wr_acc    = wr_en && !full_r;
    rd_acc    = rd_en && !empty_r;
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full_r       <= 1'b0;
      empty_r      <= 1'b1;
      prog_full_r  <= 1'b0;
      prog_empty_r <= 1'b1;
      overflow_r   <= 1'b0;
      underflow_r  <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count        <= count_nxt;
      full_r       <= (count_nxt == DEPTH_CNT);
      empty_r      <= (count_nxt == '0);
      prog_full_r  <= (count_nxt >= PF_CNT);
      prog_empty_r <= (count_nxt <= PE_CNT);
      overflow_r   <= wr_en && full_r;
      underflow_r  <= rd_en && empty_r;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is presented directly; masked to zero while empty so reset shows 0.
    assign dout  = empty_r ? '0 : mem[rd_ptr];
    assign valid = !empty_r;
  end else begin : g_std
    logic [DATA_W-1:0] dout_r;
    logic              valid_r;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_r  <= '0;
        valid_r <= 1'b0;
      end else begin
        valid_r <= rd_acc;
        if (rd_acc) begin
          dout_r <= mem[rd_ptr];
        end
      end
    end

    assign dout  = dout_r;
    assign valid = valid_r;
  end

  assign full       = full_r;
  assign empty      = empty_r;
  assign data_count = count;
  assign prog_full  = prog_full_r;
  assign prog_empty = prog_empty_r;
  assign overflow   = overflow_r;
  assign underflow  = underflow_r;

endmodule

// File: tb/tb_sync_cmd_fifo.sv
// Directed bench for sync_cmd_fifo: default standard-mode instance plus an 8-bit FWFT instance.
module tb_sync_cmd_fifo;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] din;
  logic         wr_en;
  logic         rd_en;
  logic [127:0] dout;
  logic         valid, full, empty, prog_full, prog_empty, overflow, underflow;
  logic [4:0]   data_count;

  logic [7:0]   din2;
  logic         wr_en2;
  logic         rd_en2;
  logic [7:0]   dout2;
  logic         valid2, full2, empty2, prog_full2, prog_empty2, overflow2, underflow2;
  logic [4:0]   data_count2;

  int vectors = 0;
  int miscompares = 0;
  logic [127:0] q[$];
  logic [127:0] exp_w;

  always #5 clk = ~clk;

  sync_cmd_fifo dut (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout), .valid(valid), .full(full), .empty(empty),
    .data_count(data_count), .prog_full(prog_full), .prog_empty(prog_empty),
    .overflow(overflow), .underflow(underflow)
  );

  sync_cmd_fifo #(.DATA_W(8), .ADDR_W(4), .PROG_FULL_THRESH(14),
                  .PROG_EMPTY_THRESH(2), .FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst), .din(din2), .wr_en(wr_en2), .rd_en(rd_en2),
    .dout(dout2), .valid(valid2), .full(full2), .empty(empty2),
    .data_count(data_count2), .prog_full(prog_full2), .prog_empty(prog_empty2),
    .overflow(overflow2), .underflow(underflow2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    wr_en2 = 1'b0; rd_en2 = 1'b0; din2 = '0;
    tick(); tick();
    vectors++;
    if ({dout, valid, full, empty, data_count, prog_full, prog_empty, overflow, underflow}
        !== {128'h0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_std: got dout=%0h v=%b f=%b e=%b cnt=%0d pf=%b pe=%b ov=%b un=%b",
               dout, valid, full, empty, data_count, prog_full, prog_empty, overflow, underflow);
    end
    vectors++;
    if ({dout2, valid2, full2, empty2, data_count2, prog_full2, prog_empty2, overflow2, underflow2}
        !== {8'h0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_fwft: got dout=%0h v=%b e=%b cnt=%0d pe=%b",
               dout2, valid2, empty2, data_count2, prog_empty2);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill_drain();
    integer seed = 1;
    int cnt = 0;
    q.delete();
    for (int i = 0; i < 20; i++) begin
      din = {$random(seed), $random(seed), $random(seed), $random(seed)};
      q.push_back(din);
      wr_en = 1'b1;
      tick();
      cnt++;
      vectors++;
      if (data_count !== 5'(cnt) || prog_full !== (cnt >= 14) || prog_empty !== (cnt <= 2)) begin
        miscompares++;
        $display("FAIL fill_count: got cnt=%0d pf=%b pe=%b want cnt=%0d pf=%b pe=%b",
                 data_count, prog_full, prog_empty, cnt, cnt >= 14, cnt <= 2);
      end
      if (prog_full) break;
    end
    wr_en = 1'b0;
    vectors++;
    if (data_count !== 5'd14) begin
      miscompares++;
      $display("FAIL prog_full_rise: got count=%0d want 14", data_count);
    end
    for (int i = 0; i < 20; i++) begin
      rd_en = !empty;
      tick();
      if (valid) begin
        vectors++;
        exp_w = (q.size() > 0) ? q.pop_front() : '1;
        if (dout !== exp_w) begin
          miscompares++;
          $display("FAIL drain_data: got %0h want %0h", dout, exp_w);
        end
      end
    end
    rd_en = 1'b0;
    vectors++;
    if (q.size() != 0 || data_count !== 5'd0 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_end: got left=%0d cnt=%0d empty=%b want 0 0 1", q.size(), data_count, empty);
    end
  endtask

  task automatic test_full_boundary();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; din = 128'h1000 + 128'(i);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      din = 128'hBAD0 + 128'(i);
      tick();
      vectors++;
      if (overflow !== 1'b1 || full !== 1'b1 || data_count !== 5'd16) begin
        miscompares++;
        $display("FAIL overflow_pulse: got ov=%b full=%b cnt=%0d want 1 1 16", overflow, full, data_count);
      end
    end
    wr_en = 1'b0;
    tick();
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_clear: got %b want 0", overflow);
    end
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      vectors++;
      if (valid !== 1'b1 || dout !== 128'h1000 + 128'(i)) begin
        miscompares++;
        $display("FAIL full_drain: got v=%b dout=%0h want 1 %0h", valid, dout, 128'h1000 + 128'(i));
      end
    end
    rd_en = 1'b0;
    tick();
    vectors++;
    if (empty !== 1'b1 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL full_drain_end: got e=%b v=%b want 1 0", empty, valid);
    end
  endtask

  task automatic test_empty_boundary();
    rd_en = 1'b1;
    tick();
    vectors++;
    if (underflow !== 1'b1 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL underflow_pulse: got un=%b v=%b want 1 0", underflow, valid);
    end
    rd_en = 1'b0;
    tick();
    vectors++;
    if (underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL underflow_clear: got %b want 0", underflow);
    end
    wr_en = 1'b1; rd_en = 1'b1; din = 128'h55;
    tick();
    vectors++;
    if (underflow !== 1'b1 || data_count !== 5'd1 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_simul: got un=%b cnt=%0d v=%b want 1 1 0", underflow, data_count, valid);
    end
    wr_en = 1'b0;
    tick();
    vectors++;
    if (valid !== 1'b1 || dout !== 128'h55 || data_count !== 5'd0) begin
      miscompares++;
      $display("FAIL empty_simul_read: got v=%b dout=%0h cnt=%0d want 1 55 0", valid, dout, data_count);
    end
    rd_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; din = 128'h2000 + 128'(i);
      tick();
    end
    rd_en = 1'b1; din = 128'hDEAD;
    tick();
    vectors++;
    if (overflow !== 1'b1 || data_count !== 5'd15 || full !== 1'b0 || valid !== 1'b1 || dout !== 128'h2000) begin
      miscompares++;
      $display("FAIL full_simul: got ov=%b cnt=%0d f=%b v=%b dout=%0h want 1 15 0 1 2000",
               overflow, data_count, full, valid, dout);
    end
    wr_en = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tick();
      vectors++;
      if (valid !== 1'b1 || dout !== 128'h2000 + 128'(i)) begin
        miscompares++;
        $display("FAIL full_simul_drain: got v=%b dout=%0h want 1 %0h", valid, dout, 128'h2000 + 128'(i));
      end
    end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_wrap_stream();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; din = 128'(i);
      tick();
    end
    rd_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      din = 128'(i + 5);
      tick();
      vectors++;
      if (data_count !== 5'd5 || valid !== 1'b1 || dout !== 128'(i)) begin
        miscompares++;
        $display("FAIL stream: cycle %0d got cnt=%0d v=%b dout=%0h want 5 1 %0h", i, data_count, valid, dout, i);
      end
    end
    wr_en = 1'b0;
    for (int i = 100; i < 105; i++) begin
      tick();
      vectors++;
      if (valid !== 1'b1 || dout !== 128'(i)) begin
        miscompares++;
        $display("FAIL stream_tail: got v=%b dout=%0h want 1 %0h", valid, dout, i);
      end
    end
    rd_en = 1'b0;
    tick();
    vectors++;
    if (empty !== 1'b1 || data_count !== 5'd0) begin
      miscompares++;
      $display("FAIL stream_end: got e=%b cnt=%0d want 1 0", empty, data_count);
    end
  endtask

  task automatic test_fwft();
    wr_en2 = 1'b1; din2 = 8'hA5;
    tick();
    wr_en2 = 1'b0;
    vectors++;
    if (dout2 !== 8'hA5 || valid2 !== 1'b1 || empty2 !== 1'b0) begin
      miscompares++;
      $display("FAIL fwft_fall: got dout=%0h v=%b e=%b want a5 1 0", dout2, valid2, empty2);
    end
    tick();
    vectors++;
    if (dout2 !== 8'hA5 || valid2 !== 1'b1) begin
      miscompares++;
      $display("FAIL fwft_hold: got dout=%0h v=%b want a5 1", dout2, valid2);
    end
    rd_en2 = 1'b1;
    tick();
    rd_en2 = 1'b0;
    vectors++;
    if (empty2 !== 1'b1 || valid2 !== 1'b0) begin
      miscompares++;
      $display("FAIL fwft_pop: got e=%b v=%b want 1 0", empty2, valid2);
    end
    wr_en2 = 1'b1; din2 = 8'hB1;
    tick();
    din2 = 8'hB2;
    tick();
    wr_en2 = 1'b0; rd_en2 = 1'b1;
    vectors++;
    if (dout2 !== 8'hB1 || data_count2 !== 5'd2) begin
      miscompares++;
      $display("FAIL fwft_head: got dout=%0h cnt=%0d want b1 2", dout2, data_count2);
    end
    tick();
    vectors++;
    if (dout2 !== 8'hB2 || valid2 !== 1'b1) begin
      miscompares++;
      $display("FAIL fwft_next: got dout=%0h v=%b want b2 1", dout2, valid2);
    end
    tick();
    rd_en2 = 1'b0;
    vectors++;
    if (empty2 !== 1'b1) begin
      miscompares++;
      $display("FAIL fwft_end: got e=%b want 1", empty2);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; din = 128'h300 + 128'(i);
      tick();
    end
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    vectors++;
    if (data_count !== 5'd9 || valid !== 1'b1 || dout !== 128'h300) begin
      miscompares++;
      $display("FAIL pre_reset: got cnt=%0d v=%b dout=%0h want 9 1 300", data_count, valid, dout);
    end
    #3 rst = 1'b1;
    #1;
    vectors++;
    if ({dout, valid, full, empty, data_count, prog_full, prog_empty, overflow, underflow}
        !== {128'h0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset: got dout=%0h v=%b f=%b e=%b cnt=%0d pf=%b pe=%b",
               dout, valid, full, empty, data_count, prog_full, prog_empty);
    end
    wr_en = 1'b1; din = 128'h999;
    tick();
    vectors++;
    if (data_count !== 5'd0 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ignore: got cnt=%0d e=%b want 0 1", data_count, empty);
    end
    rst = 1'b0; din = 128'h77;
    tick();
    vectors++;
    if (data_count !== 5'd1) begin
      miscompares++;
      $display("FAIL post_reset_wr: got cnt=%0d want 1", data_count);
    end
    din = 128'h88;
    tick();
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    vectors++;
    if (valid !== 1'b1 || dout !== 128'h77) begin
      miscompares++;
      $display("FAIL post_reset_first: got v=%b dout=%0h want 1 77", valid, dout);
    end
    tick();
    rd_en = 1'b0;
    vectors++;
    if (dout !== 128'h88 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_second: got dout=%0h e=%b want 88 1", dout, empty);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_boundary();
    test_empty_boundary();
    test_wrap_stream();
    test_fwft();
    test_reset_mid();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
